// File: rtl/lcd1602_pkg.sv
// Shared constants, state encodings and the init command ROM for the LCD1602 driver.
package lcd1602_pkg;

  localparam logic [7:0] CMD_FUNC    = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
  localparam logic [7:0] CMD_DISP_ON = 8'h0C;  // display on, cursor off
  localparam logic [7:0] CMD_ENTRY   = 8'h06;  // auto-increment, no shift
  localparam logic [7:0] CMD_CLEAR   = 8'h01;  // clear display (slow command)
  localparam logic [7:0] CMD_ROW1    = 8'h80;  // DDRAM address 0x00
  localparam logic [7:0] CMD_ROW2    = 8'hC0;  // DDRAM address 0x40

  localparam logic [2:0] INIT_LAST = 3'd4;     // index of the last init command

  typedef enum logic [2:0] {
    ST_PWR, ST_INIT, ST_SNAP, ST_ADDR1, ST_ROW1, ST_ADDR2, ST_ROW2, ST_GAP
  } lcd_state_e;

  typedef enum logic [2:0] {
    PH_IDLE, PH_SETUP, PH_HIGH, PH_HOLD, PH_WAIT
  } wr_phase_e;

  // Init ROM: function set is written twice, clear goes last so its long wait ends init.
  function automatic logic [7:0] init_cmd(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1: init_cmd = CMD_FUNC;
      3'd2:       init_cmd = CMD_DISP_ON;
      3'd3:       init_cmd = CMD_ENTRY;
      default:    init_cmd = CMD_CLEAR;
    endcase
  endfunction

endpackage

// File: rtl/lcd1602_drive_writer.sv
// One HD44780 byte write: setup, EN pulse, hold, then the execute wait.
// RS/DATA are loaded only when a transaction starts, so they never move around EN.
module lcd_byte_writer
  import lcd1602_pkg::*;
#(
  parameter int T_AS = 5,
  parameter int T_EH = 25,
  parameter int T_AH = 5,
  parameter int CW   = 20
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_start,
  input  logic          i_rs,
  input  logic [7:0]    i_byte,
  input  logic [CW-1:0] i_wait,
  output logic          o_busy,
  output logic          o_done,
  output logic [7:0]    o_lcd_data,
  output logic          o_lcd_rs,
  output logic          o_lcd_en
);

  localparam logic [CW-1:0] AS_M1 = CW'(T_AS - 1);
  localparam logic [CW-1:0] EH_M1 = CW'(T_EH - 1);
  localparam logic [CW-1:0] AH_M1 = CW'(T_AH - 1);

  wr_phase_e     r_ph, w_ph_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [CW-1:0] r_wait;
  logic [7:0]    r_data;
  logic          r_rs, r_en;
  logic          w_load, w_zero;

  assign w_zero = (r_cnt == '0);

  // Phase sequencing: each phase lasts (loaded count + 1) cycles, counting down to 0.
  always_comb begin
    w_ph_nxt  = r_ph;
    w_cnt_nxt = w_zero ? r_cnt : r_cnt - 1'b1;
    w_load    = 1'b0;
    case (r_ph)
      PH_IDLE: begin
        w_cnt_nxt = r_cnt;
        if (i_start) begin
          w_ph_nxt  = PH_SETUP;
          w_cnt_nxt = AS_M1;
          w_load    = 1'b1;
        end
      end
      PH_SETUP: if (w_zero) begin w_ph_nxt = PH_HIGH; w_cnt_nxt = EH_M1;         end
      PH_HIGH:  if (w_zero) begin w_ph_nxt = PH_HOLD; w_cnt_nxt = AH_M1;         end
      PH_HOLD:  if (w_zero) begin w_ph_nxt = PH_WAIT; w_cnt_nxt = r_wait - 1'b1; end
      PH_WAIT:  if (w_zero) begin w_ph_nxt = PH_IDLE;                            end
      default:  w_ph_nxt = PH_IDLE;
    endcase
  end

  // Phase/count registers; EN is registered straight from the next phase so it is glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ph   <= PH_IDLE;
      r_cnt  <= '0;
      r_wait <= '0;
      r_data <= '0;
      r_rs   <= 1'b0;
      r_en   <= 1'b0;
    end else begin
      r_ph  <= w_ph_nxt;
      r_cnt <= w_cnt_nxt;
      r_en  <= (w_ph_nxt == PH_HIGH);
      if (w_load) begin
        r_data <= i_byte;
        r_rs   <= i_rs;
        r_wait <= i_wait;
      end
    end
  end

  assign o_busy     = (r_ph != PH_IDLE);
  assign o_done     = (r_ph == PH_WAIT) && w_zero;
  assign o_lcd_data = r_data;
  assign o_lcd_rs   = r_rs;
  assign o_lcd_en   = r_en;

endmodule

// File: rtl/lcd1602_drive.sv
// LCD1602 driver top: power-up wait, init commands, then continuous two-row refresh
// from a frame snapshot so a frame on the panel is never torn by mid-frame updates.
module lcd1602_drive
  import lcd1602_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int T_PWR  = 1_000_000,
  parameter int T_AS   = 5,
  parameter int T_EH   = 25,
  parameter int T_AH   = 5,
  parameter int T_EXEC = 2_500,
  parameter int T_CLR  = 100_000,
  parameter int T_GAP  = 250_000
) (
  input  logic         CLOCK_50,
  input  logic         rst_n,
  input  logic [255:0] data_in,
  input  logic         bl_in,
  output logic [7:0]   LCD_DATA,
  output logic         LCD_RS,
  output logic         LCD_RW,
  output logic         LCD_EN,
  output logic         LCD_ON,
  output logic         LCD_BLON,
  output logic         init_done,
  output logic         frame_done
);

  localparam int CW = $clog2(T_PWR + 1);

  lcd_state_e    r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [4:0]    r_idx;
  logic [2:0]    r_init_idx;
  logic [255:0]  r_frame;
  logic          r_issued, r_init_done, r_frame_done, r_on, r_blon;

  logic          w_wr_state, w_start, w_busy, w_done, w_rs;
  logic [7:0]    w_byte;
  logic [CW-1:0] w_wait;

  // States that drive one byte write each; r_issued stops a second start for the same byte.
  assign w_wr_state = (r_state == ST_INIT) || (r_state == ST_ADDR1) || (r_state == ST_ROW1) ||
                      (r_state == ST_ADDR2) || (r_state == ST_ROW2);
  assign w_start    = w_wr_state && !w_busy && !r_issued;

  // Byte source per state; only the clear command gets the long execute wait.
  always_comb begin
    w_byte = CMD_ROW1;
    w_rs   = 1'b0;
    case (r_state)
      ST_INIT:  w_byte = init_cmd(r_init_idx);
      ST_ADDR2: w_byte = CMD_ROW2;
      ST_ROW1, ST_ROW2: begin
        w_byte = r_frame[{r_idx, 3'b000} +: 8];
        w_rs   = 1'b1;
      end
      default: ;
    endcase
    w_wait = (r_state == ST_INIT && w_byte == CMD_CLEAR) ? CW'(T_CLR) : CW'(T_EXEC);
  end

  // Sequencing FSM next state.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_PWR:   if (r_cnt == '0) w_next = ST_INIT;
      ST_INIT:  if (w_done && r_init_idx == INIT_LAST) w_next = ST_SNAP;
      ST_SNAP:  w_next = ST_ADDR1;
      ST_ADDR1: if (w_done) w_next = ST_ROW1;
      ST_ROW1:  if (w_done && r_idx == 5'd15) w_next = ST_ADDR2;
      ST_ADDR2: if (w_done) w_next = ST_ROW2;
      ST_ROW2:  if (w_done && r_idx == 5'd31) w_next = ST_GAP;
      ST_GAP:   if (r_cnt == '0) w_next = ST_SNAP;
      default:  w_next = ST_PWR;
    endcase
  end

  // State register.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) r_state <= ST_PWR;
    else        r_state <= w_next;
  end

  // Delay counter (PWR and GAP), char/init indices, frame snapshot and status flags.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= CW'(T_PWR - 1);
      r_idx        <= '0;
      r_init_idx   <= '0;
      r_frame      <= '0;
      r_issued     <= 1'b0;
      r_init_done  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      if (w_next == ST_GAP && r_state != ST_GAP)
        r_cnt <= CW'(T_GAP - 1);
      else if ((r_state == ST_PWR || r_state == ST_GAP) && r_cnt != '0)
        r_cnt <= r_cnt - 1'b1;
      if (w_start)     r_issued <= 1'b1;
      else if (w_done) r_issued <= 1'b0;
      if (w_done && r_state == ST_INIT) r_init_idx <= r_init_idx + 1'b1;
      // 5-bit index: the only wrap (31 -> 0) happens on the last char of row 2.
      if (w_done && (r_state == ST_ROW1 || r_state == ST_ROW2)) r_idx <= r_idx + 1'b1;
      if (r_state == ST_SNAP) r_frame <= data_in;
      if (w_done && r_state == ST_INIT && r_init_idx == INIT_LAST) r_init_done <= 1'b1;
      r_frame_done <= w_done && (r_state == ST_ROW2) && (r_idx == 5'd31);
    end
  end

  // Panel power and backlight, independent of the sequencer.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_on   <= 1'b0;
      r_blon <= 1'b0;
    end else begin
      r_on   <= 1'b1;
      r_blon <= bl_in;
    end
  end

  lcd_byte_writer #(
    .T_AS (T_AS),
    .T_EH (T_EH),
    .T_AH (T_AH),
    .CW   (CW)
  ) u_wr (
    .clk        (CLOCK_50),
    .rst_n      (rst_n),
    .i_start    (w_start),
    .i_rs       (w_rs),
    .i_byte     (w_byte),
    .i_wait     (w_wait),
    .o_busy     (w_busy),
    .o_done     (w_done),
    .o_lcd_data (LCD_DATA),
    .o_lcd_rs   (LCD_RS),
    .o_lcd_en   (LCD_EN)
  );

  assign LCD_RW     = 1'b0;
  assign LCD_ON     = r_on;
  assign LCD_BLON   = r_blon;
  assign init_done  = r_init_done;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_lcd1602_drive.sv
// Directed bench for lcd1602_drive with short sim timing; a negedge bus monitor logs
// every EN pulse and checks setup/hold/width, the main flow compares against hand values.
module tb_lcd1602_drive;

  localparam int T_PWR = 100, T_AS = 2, T_EH = 4, T_AH = 2;
  localparam int T_EXEC = 20, T_CLR = 60, T_GAP = 50;
  // Hand-derived edge numbers (edge 0 = first rising edge after reset release):
  // a normal write occupies 28 cycles plus one idle cycle before the next start = 29.
  localparam int FIRST_RISE = 102;    // 100 PWR cycles, start at edge 100, EN at +2
  localparam int INIT_EDGE  = 284;    // clear loaded at 100+4*29, done 68 cycles later
  localparam int FD1_EDGE   = 1271;   // ADDR1 loaded at 286, +33*29 +28
  localparam int PERIOD     = 1037;   // 50 gap + snap + start cycle + 34*29 - 1

  logic         CLOCK_50 = 1'b0;
  logic         rst_n;
  logic [255:0] data_in;
  logic         bl_in;
  logic [7:0]   LCD_DATA;
  logic         LCD_RS, LCD_RW, LCD_EN, LCD_ON, LCD_BLON, init_done, frame_done;

  lcd1602_drive #(
    .CLK_HZ (50_000_000), .T_PWR (T_PWR), .T_AS (T_AS), .T_EH (T_EH), .T_AH (T_AH),
    .T_EXEC (T_EXEC), .T_CLR (T_CLR), .T_GAP (T_GAP)
  ) dut (
    .CLOCK_50 (CLOCK_50), .rst_n (rst_n), .data_in (data_in), .bl_in (bl_in),
    .LCD_DATA (LCD_DATA), .LCD_RS (LCD_RS), .LCD_RW (LCD_RW), .LCD_EN (LCD_EN),
    .LCD_ON (LCD_ON), .LCD_BLON (LCD_BLON), .init_done (init_done), .frame_done (frame_done)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // edge counter: after rising edge E it holds E+1
  int cyc;
  always @(posedge CLOCK_50 or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  int         rise_edge[$];
  logic [8:0] rise_byte[$];
  int         init_edge[$];
  int         fd_edge[$];
  int         bus_viol = 0, rw_viol = 0, fd_wide = 0;

  // Bus monitor, sampled on the falling edge.
  initial begin
    logic [8:0] prev_bus;
    logic       prev_en, prev_init, prev_fd;
    int         chg_edge, fall_edge, hi_cnt, e;
    prev_bus = '0; prev_en = 0; prev_init = 0; prev_fd = 0;
    chg_edge = -100; fall_edge = -100; hi_cnt = 0;
    forever begin
      @(negedge CLOCK_50);
      if (!rst_n) begin
        prev_bus = '0; prev_en = 0; prev_init = 0; prev_fd = 0;
        chg_edge = -100; fall_edge = -100; hi_cnt = 0;
      end else begin
        e = cyc - 1;
        if (LCD_RW !== 1'b0) rw_viol++;
        if ({LCD_RS, LCD_DATA} !== prev_bus) begin
          if (LCD_EN || prev_en || (e - fall_edge < T_AH)) bus_viol++;
          chg_edge = e;
          prev_bus = {LCD_RS, LCD_DATA};
        end
        if (LCD_EN && !prev_en) begin
          if (e - chg_edge < T_AS) bus_viol++;
          rise_edge.push_back(e);
          rise_byte.push_back({LCD_RS, LCD_DATA});
          hi_cnt = 0;
        end
        if (LCD_EN) hi_cnt++;
        if (!LCD_EN && prev_en) begin
          if (hi_cnt != T_EH) bus_viol++;
          fall_edge = e;
        end
        prev_en = LCD_EN;
        if (init_done && !prev_init) init_edge.push_back(e);
        prev_init = init_done;
        if (frame_done) begin
          if (prev_fd) fd_wide++;
          else fd_edge.push_back(e);
        end
        prev_fd = frame_done;
      end
    end
  end

  function automatic logic [255:0] pack(input string r1, input string r2);
    logic [255:0] v;
    v = '0;
    for (int k = 0; k < 16; k++) begin
      v[8*k +: 8]      = r1[k];
      v[8*(k+16) +: 8] = r2[k];
    end
    return v;
  endfunction

  // Expected j-th bus byte (0..33) of a refresh frame built from frame vector fr.
  function automatic logic [8:0] exp_byte(input logic [255:0] fr, input int j);
    if (j == 0)       return {1'b0, 8'h80};
    else if (j <= 16) return {1'b1, fr[8*(j-1) +: 8]};
    else if (j == 17) return {1'b0, 8'hC0};
    else              return {1'b1, fr[8*(j-2) +: 8]};
  endfunction

  task automatic step();
    @(negedge CLOCK_50); #1;
  endtask

  task automatic wait_rises(input int n, input int budget);
    int k = 0;
    while (rise_edge.size() < n && k < budget) begin step(); k++; end
    if (rise_edge.size() < n) chk("wait_rises", rise_edge.size(), n);
  endtask

  task automatic wait_q(input string tag, input int which, input int n, input int budget);
    int k = 0, sz;
    sz = (which == 0) ? init_edge.size() : fd_edge.size();
    while (sz < n && k < budget) begin
      step(); k++;
      sz = (which == 0) ? init_edge.size() : fd_edge.size();
    end
    if (sz < n) chk(tag, sz, n);
  endtask

  task automatic check_init(input string tag);
    logic [7:0] cmds [5];
    cmds = '{8'h38, 8'h38, 8'h0C, 8'h06, 8'h01};
    wait_rises(5, 500);
    if (rise_edge.size() >= 5) begin
      chk({tag, "_first_rise"}, rise_edge[0], FIRST_RISE);
      for (int i = 0; i < 5; i++) chk($sformatf("%s_cmd%0d", tag, i), rise_byte[i], {1'b0, cmds[i]});
    end
  endtask

  logic [255:0] f1, f2;

  initial begin
    f1 = pack("2024/05/17 12:34", "Friday          ");
    f2 = pack("2024/05/17 12 34", "Friday          ");
    rst_n = 1'b0; bl_in = 1'b0; data_in = f1;
    repeat (3) step();
    chk("rst_outs", {LCD_DATA, LCD_RS, LCD_RW, LCD_EN, LCD_ON, LCD_BLON, init_done, frame_done}, '0);

    // 1. reset release, init sequence and init_done timing
    rst_n = 1'b1;
    step();
    chk("lcd_on_first_edge", LCD_ON, 1'b1);
    chk("init_done_early", init_done, 1'b0);
    check_init("init");
    wait_q("wait_init", 0, 1, 500);
    if (init_edge.size() > 0) begin
      chk("init_done_edge", init_edge[0], INIT_EDGE);
      chk("clear_exec_gap", init_edge[0] - (rise_edge[4] + T_EH), T_AH + T_CLR);
    end

    // 3. change char 13 while ROW1 char 5 of frame 1 is on the bus
    wait_rises(5 + 1 + 6, 600);
    data_in[8*13 +: 8] = 8'h20;

    // 2. frame content and period
    wait_q("wait_fd2", 1, 2, 3000);
    if (fd_edge.size() >= 2) begin
      chk("fd1_edge", fd_edge[0], FD1_EDGE);
      chk("frame_period", fd_edge[1] - fd_edge[0], PERIOD);
    end
    if (rise_edge.size() >= 5 + 68)
      for (int j = 0; j < 34; j++) begin
        chk($sformatf("f1_byte%0d", j), rise_byte[5 + j],      exp_byte(f1, j));
        chk($sformatf("f2_byte%0d", j), rise_byte[5 + 34 + j], exp_byte(f2, j));
      end
    else chk("frame_bytes_count", rise_edge.size(), 5 + 68);

    // 6. backlight toggle during GAP
    bl_in = 1'b1; #1;
    chk("blon_pre_edge", LCD_BLON, 1'b0);
    step();
    chk("blon_on", LCD_BLON, 1'b1);
    bl_in = 1'b0; #1;
    chk("blon_hold", LCD_BLON, 1'b1);
    step();
    chk("blon_off", LCD_BLON, 1'b0);
    wait_q("wait_fd3", 1, 3, 1500);
    if (fd_edge.size() >= 3) chk("gap_with_bl", fd_edge[2] - fd_edge[1], PERIOD);

    // 5. reset while EN is high during ROW2 of frame 4
    wait_rises(5 + 3*34 + 19, 2000);
    chk("en_before_rst", LCD_EN, 1'b1);
    rst_n = 1'b0; #1;
    chk("rst_async_en", LCD_EN, 1'b0);
    chk("rst_async_on", LCD_ON, 1'b0);
    chk("rst_async_flags", {init_done, frame_done, LCD_RS, LCD_DATA}, '0);
    rise_edge.delete(); rise_byte.delete(); init_edge.delete(); fd_edge.delete();
    repeat (3) step();
    rst_n = 1'b1;
    check_init("reinit");
    wait_q("wait_reinit", 0, 1, 500);
    if (init_edge.size() > 0) chk("reinit_done_edge", init_edge[0], INIT_EDGE);

    // 4. bus timing over the whole run
    chk("bus_timing", bus_viol, 0);
    chk("rw_zero", rw_viol, 0);
    chk("fd_width", fd_wide, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
